// File: rtl/aes_csr_block_queue.sv
// -----------------------------------------------------------------------------
// aes_csr_block_queue
//
// Avalon-MM CSR block that sits between the HPS lightweight bridge and an AES
// core. Software stages a 128-bit plaintext in PT0..PT3 and PUSHes it into an
// input FIFO. A small sequencer issues queued blocks to the core one at a time
// and captures each ciphertext into an output FIFO, whose head is visible at
// CT0..CT3. Sticky error flags and an IRQ let software stream blocks without
// polling every word.
//
// Ports
//   clk_clk          system clock
//   reset_reset      synchronous, active-high reset
//   avs_address      word address (5 bits)
//   avs_read         read strobe
//   avs_write        write strobe
//   avs_writedata    write data
//   avs_readdata     read data, registered, valid 1 cycle after avs_read
//   irq              irq_en && output FIFO non-empty
//   aes_key          key to the core, KEY0 is the most significant word
//   aes_pt           plaintext to the core, PT0 is [127:96]
//   aes_start        1-cycle start pulse to the core
//   aes_done         1-cycle completion pulse from the core
//   aes_ct           ciphertext, valid with aes_done
// -----------------------------------------------------------------------------
module aes_csr_block_queue #(
  parameter int KEY_WORDS      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [4:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    irq,
  output logic [32*KEY_WORDS-1:0] aes_key,
  output logic [127:0]            aes_pt,
  output logic                    aes_start,
  input  logic                    aes_done,
  input  logic [127:0]            aes_ct
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t              state;
  logic                irq_en;
  logic [31:0]         pt_q  [4];
  logic [31:0]         key_q [KEY_WORDS];
  logic                ovf_q, udf_q, tmo_q;
  logic [TW-1:0]       tmr;

  logic [127:0]        in_mem  [FIFO_DEPTH];
  logic [127:0]        out_mem [FIFO_DEPTH];
  logic [AW-1:0]       in_wr, in_rd, out_wr, out_rd;
  logic [CW-1:0]       in_count, out_count;

  // ---------------------------------------------------------------------------
  // Bus decode and FIFO control
  // ---------------------------------------------------------------------------
  logic wr_ctrl, wr_status, wr_cmd;
  logic flush, cmd_push, cmd_pop;
  logic in_full, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic tmo_hit;

  assign wr_ctrl   = avs_write && (avs_address == 5'h00);
  assign wr_status = avs_write && (avs_address == 5'h01);
  assign wr_cmd    = avs_write && (avs_address == 5'h02);

  // Flush wins over any CMD bits written in the same cycle.
  assign flush    = wr_ctrl && avs_writedata[1];
  assign cmd_push = wr_cmd && avs_writedata[0] && !flush;
  assign cmd_pop  = wr_cmd && avs_writedata[1] && !flush;

  assign in_full   = (in_count == CW'(FIFO_DEPTH));
  assign out_full  = (out_count == CW'(FIFO_DEPTH));
  assign out_empty = (out_count == '0);

  assign in_push  = cmd_push && !in_full;
  assign in_pop   = (state == S_START) && !flush;
  // The output slot was reserved when the block left IDLE, so this never
  // meets a full FIFO.
  assign out_push = (state == S_WAIT) && aes_done && !flush;
  assign out_pop  = cmd_pop && !out_empty;
  assign tmo_hit  = (state == S_WAIT) && !aes_done && !flush &&
                    (tmr == TW'(TIMEOUT_CYCLES - 1));

  assign irq = irq_en && !out_empty;

  logic [127:0]            pt_flat;
  logic [32*KEY_WORDS-1:0] key_flat;
  assign pt_flat = {pt_q[0], pt_q[1], pt_q[2], pt_q[3]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    key_flat = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      key_flat[32*(KEY_WORDS-1-i) +: 32] = key_q[i];
  end

  // ---------------------------------------------------------------------------
  // CSR registers and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    if (reset_reset) begin
      irq_en <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      tmo_q  <= 1'b0;
      for (int i = 0; i < 4; i++)         pt_q[i]  <= '0;
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
    end else begin
      if (wr_ctrl) irq_en <= avs_writedata[0];
      for (int i = 0; i < 4; i++)
        if (avs_write && avs_address == 5'(4 + i)) pt_q[i] <= avs_writedata;
      for (int i = 0; i < KEY_WORDS; i++)
        if (avs_write && avs_address == 5'(8 + i)) key_q[i] <= avs_writedata;
      // A new error event in the same cycle as a W1C keeps the flag set.
      ovf_q <= (ovf_q && !(wr_status && avs_writedata[3])) || (cmd_push && in_full);
      udf_q <= (udf_q && !(wr_status && avs_writedata[4])) || (cmd_pop && out_empty);
      tmo_q <= (tmo_q && !(wr_status && avs_writedata[5])) || tmo_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk) begin
    if (reset_reset || flush) begin
      in_wr     <= '0;
      in_rd     <= '0;
      in_count  <= '0;
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (in_push)  in_wr  <= in_wr + 1'b1;
      if (in_pop)   in_rd  <= in_rd + 1'b1;
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      in_count  <= in_count + CW'(in_push) - CW'(in_pop);
      out_count <= out_count + CW'(out_push) - CW'(out_pop);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy counters define
  // which entries are valid, and CT reads are masked to 0 when empty.
  always_ff @(posedge clk_clk) begin
    if (in_push)  in_mem[in_wr]   <= pt_flat;
    if (out_push) out_mem[out_wr] <= aes_ct;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // aes_pt/aes_key are loaded on the IDLE->START edge so they are stable
  // while aes_start is high; the FIFO entry itself is popped during START.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= S_IDLE;
      aes_start <= 1'b0;
      aes_pt    <= '0;
      aes_key   <= '0;
      tmr       <= '0;
    end else if (flush) begin
      state     <= S_IDLE;
      aes_start <= 1'b0;
      tmr       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_count != '0 && !out_full) begin
            state     <= S_START;
            aes_start <= 1'b1;
            aes_pt    <= in_mem[in_rd];
            aes_key   <= key_flat;
          end
        end
        S_START: begin
          state     <= S_WAIT;
          aes_start <= 1'b0;
          tmr       <= '0;
        end
        S_WAIT: begin
          if (aes_done || tmo_hit) state <= S_IDLE;
          else                     tmr   <= tmr + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0]  rd_mux;
  logic [127:0] ct_head;
  assign ct_head = out_mem[out_rd];

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      5'h00: rd_mux = {31'd0, irq_en};
      5'h01: rd_mux = {8'd0, 8'(out_count), 8'(in_count), 2'd0,
                       tmo_q, udf_q, ovf_q, out_empty, in_full, state != S_IDLE};
      5'h04, 5'h05, 5'h06, 5'h07: rd_mux = pt_q[avs_address[1:0]];
      5'h10, 5'h11, 5'h12, 5'h13: begin
        if (!out_empty) begin
          case (avs_address[1:0])
            2'd0:    rd_mux = ct_head[127:96];
            2'd1:    rd_mux = ct_head[95:64];
            2'd2:    rd_mux = ct_head[63:32];
            default: rd_mux = ct_head[31:0];
          endcase
        end
      end
      default: rd_mux = '0;
    endcase
    // Key words beyond KEY_WORDS have no storage and fall through as 0.
    for (int i = 0; i < KEY_WORDS; i++)
      if (avs_address == 5'(8 + i)) rd_mux = key_q[i];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)   avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
    else               avs_readdata <= '0;
  end

endmodule
